// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl
// Decides when the pipeline must take an interrupt, based on the CP0 Status
// register, the Cause software-interrupt bits and the hardware interrupt pins.
// The asynchronous pins are synchronised, and the resulting pending bits are
// also returned to Cause.IP[7:2]. A request is held until the commit stage
// acknowledges it or the request is masked away.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous, active-high reset
//   ext_int[5:0]     asynchronous hardware interrupt pins, level, active-high
//   timer_int        Count==Compare level, synchronous to clk
//   cp0_Status_data  Status register (IE=bit0, EXL=bit1, IM=bits[15:8])
//   cause_ip_sw[1:0] Cause.IP[1:0] software interrupts
//   int_ack          commit stage took the interrupt this cycle (pulse)
//   eret_op          ERET committed this cycle (pulse)
//   cause_ip_hw[5:0] synchronised hardware pending bits for Cause.IP[7:2]
//   int_req          interrupt request to the commit stage
//   int_num[2:0]     highest-priority pending, enabled interrupt index
//
// State | meaning
// IDLE  | no request; waiting for an enabled, pending interrupt
// REQ   | int_req asserted; winner index re-evaluated every cycle
// BLOCK | interrupt taken; request held off until EXL shows up or ERET
module cp0_int_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter bit TIMER_OR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ext_int,
    input  logic        timer_int,
    input  logic [31:0] cp0_Status_data,
    input  logic [1:0]  cause_ip_sw,
    input  logic        int_ack,
    input  logic        eret_op,
    output logic [5:0]  cause_ip_hw,
    output logic        int_req,
    output logic [2:0]  int_num
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BLOCK = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic [2:0] num_q, num_d;
    logic [2:0] win;
    logic       timer_bit;
    logic       st_ie, st_exl;
    logic [7:0] st_im;
    logic [5:0] hw_pend;
    logic [7:0] pend;
    logic [7:0] enabled;
    logic       unused_status;

    assign st_ie  = cp0_Status_data[0];
    assign st_exl = cp0_Status_data[1];
    assign st_im  = cp0_Status_data[15:8];
    assign unused_status = ^{cp0_Status_data[31:16], cp0_Status_data[7:2]};

    assign timer_bit = TIMER_OR_EN ? timer_int : 1'b0;

    // The timer is already synchronous, so it is folded into the last stage of
    // line 5 only; that keeps cause_ip_hw a pure register output while the
    // pin path still sees SYNC_STAGES flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= ext_int;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_q[SYNC_STAGES-1][5] <= sync_q[SYNC_STAGES-2][5] | timer_bit;
        end
    end

    assign cause_ip_hw = sync_q[SYNC_STAGES-1];

    // The live timer level is ORed in here as well so a timer interrupt
    // reaches int_req one cycle after it rises.
    assign hw_pend = {sync_q[SYNC_STAGES-1][5] | timer_bit, sync_q[SYNC_STAGES-1][4:0]};
    assign pend    = {hw_pend, cause_ip_sw};
    assign enabled = pend & st_im & {8{st_ie & ~st_exl}};

    // Highest set index wins.
    always_comb begin
        win = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (enabled[i]) begin
                win = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        case (state_q)
            IDLE: begin
                if (enabled != 8'd0) begin
                    state_d = REQ;
                    num_d   = win;
                end
            end
            REQ: begin
                // An ack completes the handshake even if the source vanished
                // in the same cycle.
                if (int_ack) begin
                    state_d = BLOCK;
                end else if (enabled == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    num_d = win;
                end
            end
            BLOCK: begin
                if (st_exl || eret_op) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign int_req = (state_q == REQ);
    assign int_num = num_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
module tb_cp0_int_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  ext_int;
    logic        timer_int;
    logic [31:0] cp0_Status_data;
    logic [1:0]  cause_ip_sw;
    logic        int_ack;
    logic        eret_op;
    logic [5:0]  cause_ip_hw;
    logic        int_req;
    logic [2:0]  int_num;

    int n_pass;
    int n_total;

    cp0_int_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .ext_int         (ext_int),
        .timer_int       (timer_int),
        .cp0_Status_data (cp0_Status_data),
        .cause_ip_sw     (cause_ip_sw),
        .int_ack         (int_ack),
        .eret_op         (eret_op),
        .cause_ip_hw     (cause_ip_hw),
        .int_req         (int_req),
        .int_num         (int_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       req;
        logic [2:0] num;
        logic [5:0] hw;
    } exp_t;

    typedef struct {
        logic [31:0] status;
        logic [1:0]  sw;
        logic        timer;
        logic        req;
        logic [2:0]  num;
        logic [5:0]  hw;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[10];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Push the expectation for the coming edge, clock, then pop and compare.
    task automatic step(input string nm, input logic req, input logic [2:0] num, input logic [5:0] hw);
        exp_t e;
        exp_q.push_back('{name: nm, req: req, num: num, hw: hw});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({e.name, ".int_req"}, {7'd0, int_req}, {7'd0, e.req});
        check({e.name, ".int_num"}, {5'd0, int_num}, {5'd0, e.num});
        check({e.name, ".cause_ip_hw"}, {2'd0, cause_ip_hw}, {2'd0, e.hw});
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        ext_int         = 6'd0;
        timer_int       = 1'b0;
        cp0_Status_data = 32'd0;
        cause_ip_sw     = 2'd0;
        int_ack         = 1'b0;
        eret_op         = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        //            status         sw     tmr   req   num   hw
        vecs[0] = '{32'h0000_FF01, 2'b01, 1'b1, 1'b1, 3'd7, 6'b100000};
        vecs[1] = '{32'h0000_FF01, 2'b11, 1'b0, 1'b1, 3'd1, 6'b000000};
        vecs[2] = '{32'h0000_0101, 2'b11, 1'b0, 1'b1, 3'd0, 6'b000000};
        vecs[3] = '{32'h0000_FF00, 2'b11, 1'b1, 1'b0, 3'd0, 6'b100000};
        vecs[4] = '{32'h0000_FF03, 2'b11, 1'b0, 1'b0, 3'd0, 6'b000000};
        vecs[5] = '{32'h0000_0001, 2'b11, 1'b1, 1'b0, 3'd0, 6'b100000};
        vecs[6] = '{32'h0000_8001, 2'b01, 1'b1, 1'b1, 3'd7, 6'b100000};
        vecs[7] = '{32'h0000_0201, 2'b11, 1'b0, 1'b1, 3'd1, 6'b000000};
        vecs[8] = '{32'h0000_7F01, 2'b10, 1'b1, 1'b1, 3'd1, 6'b100000};
        vecs[9] = '{32'hFFFF_FF01, 2'b01, 1'b0, 1'b1, 3'd0, 6'b000000};

        do_reset();
        check("reset.int_req", {7'd0, int_req}, 8'd0);
        check("reset.int_num", {5'd0, int_num}, 8'd0);
        check("reset.cause_ip_hw", {2'd0, cause_ip_hw}, 8'd0);

        // Single-cycle decisions from IDLE.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            cp0_Status_data = vecs[i].status;
            cause_ip_sw     = vecs[i].sw;
            timer_int       = vecs[i].timer;
            step($sformatf("vec%0d", i), vecs[i].req, vecs[i].num, vecs[i].hw);
        end

        // Pin to request: cause_ip_hw after 2 edges, int_req after 3.
        do_reset();
        cp0_Status_data = 32'h0000_0401;
        ext_int         = 6'b000001;
        step("pin.c1", 1'b0, 3'd0, 6'b000000);
        step("pin.c2", 1'b0, 3'd0, 6'b000001);
        step("pin.c3", 1'b1, 3'd2, 6'b000001);

        // Reset in the middle of the request acts without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid.int_req", {7'd0, int_req}, 8'd0);
        check("rst_mid.int_num", {5'd0, int_num}, 8'd0);
        check("rst_mid.cause_ip_hw", {2'd0, cause_ip_hw}, 8'd0);
        ext_int = 6'd0;
        cp0_Status_data = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("rst_mid.idle", 1'b0, 3'd0, 6'b000000);
        cp0_Status_data = 32'h0000_0301;
        cause_ip_sw     = 2'b01;
        step("rst_mid.rereq", 1'b1, 3'd0, 6'b000000);

        // Winner re-latched while in REQ.
        cause_ip_sw = 2'b11;
        step("relatch", 1'b1, 3'd1, 6'b000000);

        // Mask withdrawal returns to IDLE without an ack.
        cp0_Status_data = 32'h0000_0300;
        step("mask.drop", 1'b0, 3'd1, 6'b000000);
        cp0_Status_data = 32'h0000_0101;
        cause_ip_sw     = 2'b01;
        step("mask.back", 1'b1, 3'd0, 6'b000000);

        // Ack handshake followed by EXL then ERET.
        int_ack = 1'b1;
        step("ack.drop", 1'b0, 3'd0, 6'b000000);
        int_ack = 1'b0;
        cp0_Status_data = 32'h0000_0103;
        step("ack.exl1", 1'b0, 3'd0, 6'b000000);
        step("ack.exl2", 1'b0, 3'd0, 6'b000000);
        cp0_Status_data = 32'h0000_0101;
        eret_op = 1'b1;
        step("ack.eret", 1'b1, 3'd0, 6'b000000);
        eret_op = 1'b0;

        // Ack and mask together: ack wins, BLOCK holds until ERET.
        int_ack = 1'b1;
        cp0_Status_data = 32'h0000_0100;
        step("ackmask.blk", 1'b0, 3'd0, 6'b000000);
        int_ack = 1'b0;
        cp0_Status_data = 32'h0000_0101;
        step("ackmask.hold1", 1'b0, 3'd0, 6'b000000);
        step("ackmask.hold2", 1'b0, 3'd0, 6'b000000);
        eret_op = 1'b1;
        step("ackmask.eret", 1'b0, 3'd0, 6'b000000);
        eret_op = 1'b0;
        step("ackmask.rereq", 1'b1, 3'd0, 6'b000000);

        // One-cycle pin pulse on a masked line.
        do_reset();
        cp0_Status_data = 32'h0000_D701;
        ext_int = 6'b001000;
        step("glitch.c1", 1'b0, 3'd0, 6'b000000);
        ext_int = 6'b000000;
        step("glitch.c2", 1'b0, 3'd0, 6'b001000);
        step("glitch.c3", 1'b0, 3'd0, 6'b000000);
        step("glitch.c4", 1'b0, 3'd0, 6'b000000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cp0_int_ctrl.md
# cp0_int_ctrl

Interrupt-request generator that reads the CP0 Status register, the Cause software-interrupt bits and the hardware interrupt lines, and decides when the pipeline must take an interrupt. It sits between the CP0 register file and the commit/exception stage. It synchronises the asynchronous interrupt pins and feeds the hardware pending bits back to Cause. It holds a request until the pipeline acknowledges it or the request is masked away.

## Interface
- SYNC_STAGES, 2, flip-flop stages on each ext_int bit; legal values 2..4
- TIMER_OR_EN, 1, when 1 timer_int is ORed into hardware line 5 (IP7)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- ext_int  input  6  asynchronous hardware interrupt pins, level-sensitive, active-high
- timer_int  input  1  Count==Compare level from the timer, synchronous to clk
- cp0_Status_data  input  32  current Status: IE=bit0, EXL=bit1, IM=bits[15:8]
- cause_ip_sw  input  2  Cause.IP[1:0] (software interrupts)
- int_ack  input  1  one-cycle pulse: commit stage has taken the interrupt this cycle
- eret_op  input  1  one-cycle pulse: ERET committed
- cause_ip_hw  output  6  synchronised hardware pending bits for Cause.IP[7:2]
- int_req  output  1  interrupt request to the commit stage
- int_num  output  3  index (0..7) of the highest-priority pending, enabled interrupt

## Operation
- Synchroniser: each ext_int bit passes through SYNC_STAGES flops, all reset to 0.
- hw_pend[5:0] = synchronised ext_int, with bit5 |= timer_int when TIMER_OR_EN=1. cause_ip_hw = hw_pend, driven from registers only.
- pend[7:0] = {hw_pend, cause_ip_sw}.
- enabled[7:0] = pend & IM & {8{IE & ~EXL}}.
- Priority: the highest set index of enabled wins, so bit 7 beats bit 0.
- FSM states are IDLE, REQ and BLOCK; reset state is IDLE.
  - IDLE: if enabled != 0, go to REQ and latch int_num = winning index.
  - REQ: int_req=1.
    - If int_ack, go to BLOCK.
    - Otherwise, if enabled == 0 (pin dropped, IE cleared, IM cleared or EXL set by another exception), go to IDLE.
    - Otherwise stay in REQ and re-latch int_num each cycle with the current winner.
  - BLOCK: int_req=0. Go to IDLE when the EXL bit of cp0_Status_data is 1 or eret_op is 1; otherwise stay.
- int_ack outside REQ is ignored. eret_op outside BLOCK is ignored.
- int_num holds its value outside REQ.

## Timing
- Reset values: int_req=0, int_num=0, cause_ip_hw=0, all synchroniser flops 0, state IDLE. Reset takes effect immediately, mid-request included, and int_req drops without waiting for clk.
- ext_int to cause_ip_hw latency is SYNC_STAGES cycles.
- ext_int to int_req latency is SYNC_STAGES+1 cycles, i.e. 3 with the default, when IE=1, EXL=0 and IM is set.
- timer_int, cause_ip_sw or Status change to int_req latency is 1 cycle: enabled is combinational and int_req is the registered state.
- Request deassertion:
  - Masking while in REQ drops int_req in the next cycle.
  - int_ack drops int_req in the next cycle.
  - int_req and int_ack in the same cycle are a completed handshake.
- Simultaneous int_ack and enabled==0 in REQ: int_ack wins, next state is BLOCK.
- BLOCK guarantees int_req stays low for at least one cycle after the ack. This covers the one-cycle gap before the Status register shows EXL=1.
- If EXL is already 1 on entry to BLOCK, leave BLOCK on the next edge.

## Test plan
- Reset mid-REQ: assert rst while int_req=1 -> int_req, int_num and cause_ip_hw are 0 immediately, and the FSM is IDLE after release.
- Pin to request: Status=0x0000_0401 (IE=1, IM2=1), raise ext_int[0] at cycle 0 -> cause_ip_hw=6'b000001 at cycle 2, int_req=1 and int_num=2 at cycle 3.
- Priority and timer:
  - Setup: IM=0xFF, IE=1, cause_ip_sw=2'b01, timer_int=1 in the same cycle.
  - Required: int_req=1 next cycle with int_num=7, and cause_ip_hw[5]=1.
- Mask withdrawal: in REQ, set Status IE=0 -> int_req=0 next cycle, FSM IDLE, no ack required.
- Ack handshake:
  - Setup: int_ack pulse in REQ, with Status EXL rising one cycle later and the source still pending.
  - Required: int_req is low for at least 1 cycle and stays low while EXL=1.
  - Then, after EXL is cleared by eret and Status shows EXL=0 with the source still pending: int_req=1 again one cycle later.
- Glitch filter: a 1-cycle ext_int[3] pulse with IM5 cleared -> cause_ip_hw[3] pulses for 1 cycle and int_req stays 0.
